// File: rtl/countdown_pkg.sv
// Shared types and helpers for the two-stage countdown timer.
// State encoding and a constant width function.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/down_stage_mod.sv
// One modulo-(MAX+1) down-counting stage.
// Clear beats load, load beats decrement.
import countdown_pkg::*;

module down_stage_mod #(
  parameter int MAX = 12,
  parameter int W   = clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         Reset_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         is_zero,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] q;

  // Stage value: zero, preset, or one step down with wrap to MAX.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (dec) begin
      q <= is_zero ? MAX_V : q - 1'b1;
    end
  end

  assign value   = q;
  assign is_zero = (q == '0);
  assign wrap    = dec & is_zero & ~clr & ~load;

endmodule

// File: rtl/countdown_timer_mn.sv
// Two-stage loadable countdown timer with IDLE/RUN/PAUSE/DONE FSM.
// Optional macro AUTO_RELOAD_EN reloads the saved preset on expiry.
import countdown_pkg::*;

module countdown_timer_mn #(
  parameter int M = 12,
  parameter int N = 5,
  localparam int WL = clog2(M + 1),
  localparam int WH = clog2(N + 1)
) (
  input  logic          clk,
  input  logic          Reset_n,
  input  logic          enable,
  input  logic          clear,
  input  logic          load,
  input  logic [WL-1:0] load_low,
  input  logic [WH-1:0] load_high,
  input  logic          start,
  input  logic          pause,
  output logic [WL-1:0] count_low,
  output logic [WH-1:0] count_high,
  output logic          borrow_low,
  output logic          done_pulse,
  output logic          expired,
  output logic          running,
  output logic [1:0]    state
);

  localparam logic [WL-1:0] M_V  = WL'(M);
  localparam logic [WH-1:0] N_V  = WH'(N);
  localparam logic [WL-1:0] ONE_L = WL'(1);

  state_t st, nxt;

  logic [WL-1:0] lo_val, pre_lo, cl_lo, ld_lo;
  logic [WH-1:0] hi_val, pre_hi, cl_hi, ld_hi;
  logic          lo_zero, hi_zero;
  logic          lo_wrap, hi_wrap;
  logic          both_zero, pre_zero;
  logic          ld_ok, ps_ok, st_ok;
  logic          dec_lo, expire, reload, cnt_load;
  logic          borrow_d, done_d;
  logic          br_q, dp_q;

  assign cl_lo = (load_low  > M_V) ? M_V : load_low;
  assign cl_hi = (load_high > N_V) ? N_V : load_high;

  assign both_zero = lo_zero & hi_zero;
  assign pre_zero  = (pre_lo == '0) & (pre_hi == '0);

  assign ld_ok = load & (st != ST_RUN) & ~clear;
  assign ps_ok = pause & (st == ST_RUN) & ~clear;
  assign st_ok = start & ~clear & ~ld_ok
               & ((st == ST_IDLE) | (st == ST_PAUSE));

  assign dec_lo = (st == ST_RUN) & enable & ~clear
                & ~pause & ~both_zero;
  assign expire = dec_lo & hi_zero & (lo_val == ONE_L);

`ifdef AUTO_RELOAD_EN
  assign reload = expire & ~pre_zero;
`else
  assign reload = 1'b0;
`endif

  assign cnt_load = ld_ok | reload;
  assign ld_lo    = reload ? pre_lo : cl_lo;
  assign ld_hi    = reload ? pre_hi : cl_hi;

  down_stage_mod #(.MAX(M), .W(WL)) u_low (
    .clk      (clk),
    .Reset_n  (Reset_n),
    .clr      (clear),
    .load     (cnt_load),
    .load_val (ld_lo),
    .dec      (dec_lo),
    .value    (lo_val),
    .is_zero  (lo_zero),
    .wrap     (lo_wrap)
  );

  down_stage_mod #(.MAX(N), .W(WH)) u_high (
    .clk      (clk),
    .Reset_n  (Reset_n),
    .clr      (clear),
    .load     (cnt_load),
    .load_val (ld_hi),
    .dec      (lo_wrap),
    .value    (hi_val),
    .is_zero  (hi_zero),
    .wrap     (hi_wrap)
  );

  assign borrow_d = lo_wrap & ~hi_wrap;
  assign done_d   = expire | (st_ok & both_zero);

  // Saved preset, captured whenever a load is accepted.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pre_lo <= '0;
      pre_hi <= '0;
    end else if (ld_ok) begin
      pre_lo <= cl_lo;
      pre_hi <= cl_hi;
    end
  end

  // One-cycle borrow and expiry pulses.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      br_q <= 1'b0;
      dp_q <= 1'b0;
    end else begin
      br_q <= borrow_d;
      dp_q <= done_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) st <= ST_IDLE;
    else          st <= nxt;
  end

  // Next state in control priority order.
  always_comb begin
    nxt = st;
    if (clear) begin
      nxt = ST_IDLE;
    end else if (ld_ok) begin
      nxt = (st == ST_DONE) ? ST_IDLE : st;
    end else if (ps_ok) begin
      nxt = ST_PAUSE;
    end else if (st_ok) begin
      nxt = both_zero ? ST_DONE : ST_RUN;
    end else if (expire & ~reload) begin
      nxt = ST_DONE;
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    running = 1'b0;
    expired = 1'b0;
    unique case (st)
      ST_RUN:  running = 1'b1;
      ST_DONE: expired = 1'b1;
      default: ;
    endcase
  end

  assign count_low  = lo_val;
  assign count_high = hi_val;
  assign borrow_low = br_q;
  assign done_pulse = dp_q;
  assign state      = st;

endmodule

// File: tb/tb_countdown_timer_mn.sv
// Scoreboard bench for countdown_timer_mn (M=12, N=5).
// Stimulus queues expected outputs; a negedge monitor compares.
module tb_countdown_timer_mn;

  logic       clk;
  logic       Reset_n;
  logic       enable, clear, load, start, pause;
  logic [3:0] load_low;
  logic [2:0] load_high;
  logic [3:0] count_low;
  logic [2:0] count_high;
  logic       borrow_low, done_pulse, expired, running;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  logic [12:0] exp_q[$];
  string       name_q[$];
  logic [12:0] e_v, a_v;
  string       e_n;

  countdown_timer_mn #(.M(12), .N(5)) dut (
    .clk        (clk),
    .Reset_n    (Reset_n),
    .enable     (enable),
    .clear      (clear),
    .load       (load),
    .load_low   (load_low),
    .load_high  (load_high),
    .start      (start),
    .pause      (pause),
    .count_low  (count_low),
    .count_high (count_high),
    .borrow_low (borrow_low),
    .done_pulse (done_pulse),
    .expired    (expired),
    .running    (running),
    .state      (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [12:0] pk(
    int lo, int hi, int br, int dp,
    int ex, int rn, int st
  );
    return {4'(lo), 3'(hi), 1'(br), 1'(dp),
            1'(ex), 1'(rn), 2'(st)};
  endfunction

  task automatic chk(
    input string n, input int lo, input int hi,
    input int br, input int dp, input int ex,
    input int rn, input int st
  );
    exp_q.push_back(pk(lo, hi, br, dp, ex, rn, st));
    name_q.push_back(n);
  endtask

  task automatic tick(
    input logic en, input logic cl, input logic ld,
    input logic [3:0] ll, input logic [2:0] lh,
    input logic sa, input logic pa
  );
    enable    = en;
    clear     = cl;
    load      = ld;
    load_low  = ll;
    load_high = lh;
    start     = sa;
    pause     = pa;
    @(posedge clk);
    #1;
  endtask

  // Monitor: one queued expectation per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_v = exp_q.pop_front();
      e_n = name_q.pop_front();
      a_v = {count_low, count_high, borrow_low,
             done_pulse, expired, running, state};
      checks++;
      if (a_v !== e_v) begin
        errors++;
        $display("FAIL %s: got lo=%0d hi=%0d br=%b dp=%b ex=%b rn=%b st=%0d, want lo=%0d hi=%0d br=%b dp=%b ex=%b rn=%b st=%0d",
          e_n, a_v[12:9], a_v[8:6], a_v[5], a_v[4],
          a_v[3], a_v[2], a_v[1:0], e_v[12:9], e_v[8:6],
          e_v[5], e_v[4], e_v[3], e_v[2], e_v[1:0]);
      end
    end
  end

  initial begin
    int r;
    Reset_n   = 1'b0;
    enable    = 1'b0;
    clear     = 1'b0;
    load      = 1'b0;
    load_low  = '0;
    load_high = '0;
    start     = 1'b0;
    pause     = 1'b0;
    #1;
    chk("reset", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    Reset_n = 1'b1;

`ifdef AUTO_RELOAD_EN
    tick(0, 0, 1, 4'd2, 3'd0, 0, 0);
    chk("ar_load", 2, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 4'd0, 3'd0, 1, 0);
    chk("ar_start", 2, 0, 0, 0, 0, 1, 1);
    for (int i = 1; i <= 6; i++) begin
      tick(1, 0, 0, 4'd0, 3'd0, 0, 0);
      if (i % 2 == 0) chk("ar_reload", 2, 0, 0, 1, 0, 1, 1);
      else            chk("ar_count", 1, 0, 0, 0, 0, 1, 1);
    end
    tick(0, 1, 0, 4'd0, 3'd0, 0, 0);
    chk("ar_clear", 0, 0, 0, 0, 0, 0, 0);
`else
    tick(0, 0, 1, 4'd2, 3'd1, 0, 0);
    chk("load_2_1", 2, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 4'd0, 3'd0, 1, 0);
    chk("start_2_1", 2, 1, 0, 0, 0, 1, 1);
    for (int i = 1; i <= 15; i++) begin
      tick(1, 0, 0, 4'd0, 3'd0, 0, 0);
      r = 15 - i;
      if (i == 15)
        chk("expire", 0, 0, 0, 1, 1, 0, 3);
      else
        chk("countdown", r % 13, r / 13,
            (i == 3) ? 1 : 0, 0, 0, 1, 1);
    end
    tick(1, 0, 0, 4'd0, 3'd0, 0, 0);
    chk("done_hold", 0, 0, 0, 0, 1, 0, 3);
`endif

    tick(0, 1, 0, 4'd0, 3'd0, 0, 0);
    chk("clear", 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 4'd15, 3'd7, 0, 0);
    chk("clamp", 12, 5, 0, 0, 0, 0, 0);

    tick(0, 0, 1, 4'd5, 3'd2, 0, 0);
    chk("load_5_2", 5, 2, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 4'd0, 3'd0, 1, 0);
    chk("start_5_2", 5, 2, 0, 0, 0, 1, 1);
    tick(1, 0, 0, 4'd0, 3'd0, 0, 1);
    chk("pause_wins", 5, 2, 0, 0, 0, 0, 2);
    tick(0, 0, 0, 4'd0, 3'd0, 1, 0);
    chk("resume", 5, 2, 0, 0, 0, 1, 1);
    tick(1, 0, 0, 4'd0, 3'd0, 0, 0);
    chk("dec_4_2", 4, 2, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 4'd0, 3'd0, 0, 0);
    chk("en0_hold", 4, 2, 0, 0, 0, 1, 1);
    tick(0, 0, 1, 4'd1, 3'd1, 0, 0);
    chk("load_in_run", 4, 2, 0, 0, 0, 1, 1);

    tick(0, 1, 0, 4'd0, 3'd0, 0, 0);
    chk("clear2", 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 4'd7, 3'd3, 0, 0);
    chk("load_7_3", 7, 3, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 4'd0, 3'd0, 1, 0);
    chk("start_7_3", 7, 3, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 4'd0, 3'd0, 0, 0);
    chk("run_7_3", 7, 3, 0, 0, 0, 1, 1);
    @(posedge clk);
    #1;
    Reset_n = 1'b0;
    chk("async_reset", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    Reset_n = 1'b1;

    tick(0, 0, 1, 4'd0, 3'd0, 0, 0);
    chk("load_0_0", 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 4'd0, 3'd0, 1, 0);
    chk("start_zero", 0, 0, 0, 1, 1, 0, 3);
    tick(1, 0, 0, 4'd0, 3'd0, 0, 0);
    chk("done_en1", 0, 0, 0, 0, 1, 0, 3);
    tick(1, 0, 0, 4'd0, 3'd0, 0, 0);
    chk("done_en2", 0, 0, 0, 0, 1, 0, 3);
    tick(0, 0, 1, 4'd3, 3'd0, 0, 0);
    chk("load_from_done", 3, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 4'd0, 3'd0, 1, 0);
    chk("start_3_0", 3, 0, 0, 0, 0, 1, 1);
    tick(0, 1, 0, 4'd0, 3'd0, 0, 0);
    chk("clear3", 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending, want 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
